// File: rtl/card_shoe_if.sv
// card_shoe_if: deal/shuffle controls and presented-card status between the game FSM and the card shoe.
interface card_shoe_if;
    logic       deal;
    logic       shuffle;
    logic [3:0] new_card;
    logic       card_valid;
    logic [8:0] cards_left;
    logic       shoe_low;

    modport master (
        output deal, shuffle,
        input  new_card, card_valid, cards_left, shoe_low
    );

    modport slave (
        input  deal, shuffle,
        output new_card, card_valid, cards_left, shoe_low
    );
endinterface

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card source for the baccarat datapath.
// Define CARD_SHOE_TRACK_EN for a finite, depleting shoe; otherwise the shoe is infinite.
module card_shoe #(
    parameter int unsigned DECKS        = 1,
    parameter int unsigned RESHUFFLE_AT = 6
) (
    input  logic       slow_clock,
    input  logic       resetb,
    card_shoe_if.slave bus
);
    typedef enum logic [1:0] {PRIME, READY, EMPTY} state_t;

    localparam logic [5:0] FULL_RANK = 6'(DECKS * 4);
    localparam logic [8:0] FULL_SHOE = 9'(DECKS * 52);
    localparam logic [8:0] LOW_AT    = 9'(RESHUFFLE_AT);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  card_q, card_d;
    logic        valid_q, valid_d;
    logic [8:0]  left_q, left_d;
    logic [3:0]  cand;
    logic [3:0]  sel;
    logic        refill;

    // Fibonacci taps 16,14,13,11 in right-shift form.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign cand   = (lfsr_q[3:0] >= 4'd13) ? lfsr_q[3:0] - 4'd12 : lfsr_q[3:0] + 4'd1;
    assign refill = bus.shuffle && (state_q != PRIME);

`ifdef CARD_SHOE_TRACK_EN
    logic [5:0] cnt_q [1:13];
    logic [5:0] cnt_d [1:13];
    logic       taken;
    logic [4:0] probe;

    always_comb begin
        cnt_d  = cnt_q;
        left_d = left_q;
        taken  = 1'b0;
        if (refill) begin
            cnt_d  = '{default: FULL_RANK};
            left_d = FULL_SHOE;
        end else if (bus.deal && state_q == READY) begin
            for (int unsigned r = 1; r <= 13; r++) begin
                if (card_q == 4'(r) && cnt_q[4'(r)] != '0) begin
                    cnt_d[4'(r)] = cnt_q[4'(r)] - 6'd1;
                    taken        = 1'b1;
                end
            end
            if (taken) begin
                left_d = left_q - 9'd1;
            end
        end
    end

    // Probe from the candidate upward over the post-deal counts, wrapping 13 -> 1.
    always_comb begin
        sel   = '0;
        probe = '0;
        for (int unsigned i = 0; i < 13; i++) begin
            probe = 5'(cand) + 5'(i);
            if (probe > 5'd13) begin
                probe = probe - 5'd13;
            end
            if (sel == '0 && cnt_d[probe[3:0]] != '0) begin
                sel = probe[3:0];
            end
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '{default: FULL_RANK};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign left_d = left_q;
    assign sel    = cand;
`endif

    always_comb begin
        state_d = state_q;
        card_d  = card_q;
        valid_d = valid_q;
        if (refill) begin
            state_d = PRIME;
            card_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                PRIME: begin
                    state_d = READY;
                    card_d  = sel;
                    valid_d = 1'b1;
                end
                READY: begin
                    if (bus.deal) begin
                        if (left_d == '0) begin
                            state_d = EMPTY;
                            card_d  = '0;
                            valid_d = 1'b0;
                        end else begin
                            card_d = sel;
                        end
                    end
                end
                EMPTY: begin
                    card_d  = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = PRIME;
                    card_d  = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= PRIME;
            lfsr_q  <= 16'hACE1;
            card_q  <= '0;
            valid_q <= 1'b0;
            left_q  <= FULL_SHOE;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            left_q  <= left_d;
        end
    end

    assign bus.new_card   = card_q;
    assign bus.card_valid = valid_q;
    assign bus.cards_left = left_q;
    assign bus.shoe_low   = (left_q < LOW_AT);
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed self-checking bench for card_shoe (DECKS=1, RESHUFFLE_AT=6).
module tb_card_shoe;
    logic slow_clock;
    logic resetb;
    int   tests;
    int   failed;
    int   hist [16];
    logic [15:0] m_lfsr;
    logic [15:0] m_used;

    card_shoe_if bus ();

    card_shoe #(
        .DECKS        (1),
        .RESHUFFLE_AT (6)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    // Reference generator: m_used is the LFSR state consumed at the most recent edge.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            m_lfsr <= 16'hACE1;
            m_used <= 16'hACE1;
        end else begin
            m_used <= m_lfsr;
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    function automatic logic [15:0] cand_of(input logic [15:0] s);
        logic [4:0] n;
        n = {1'b0, s[3:0]};
        if (n >= 5'd13) n = n - 5'd13;
        return 16'(n + 5'd1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.deal    = 1'b0;
        bus.shuffle = 1'b0;
        resetb      = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        for (int r = 0; r < 16; r++) hist[r] = 0;
    endtask

    task automatic deal_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.deal = 1'b1;
            if (bus.card_valid === 1'b1) hist[bus.new_card]++;
            @(posedge slow_clock);
            #1;
        end
        bus.deal = 1'b0;
    endtask

    task automatic check_hist(input int each);
        for (int r = 1; r <= 13; r++)
            check($sformatf("hist_rank%0d", r), 16'(hist[r]), 16'(each));
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        slow_clock  = 1'b0;
        resetb      = 1'b0;
        bus.deal    = 1'b0;
        bus.shuffle = 1'b0;
        for (int r = 0; r < 16; r++) hist[r] = 0;

        #12;
        check("rst_card",  16'(bus.new_card),   16'd0);
        check("rst_valid", 16'(bus.card_valid), 16'd0);
        check("rst_left",  16'(bus.cards_left), 16'd52);
        check("rst_low",   16'(bus.shoe_low),   16'd0);

        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check("first_valid", 16'(bus.card_valid), 16'd1);
        check("first_card",  16'(bus.new_card),   16'd2);
        check("first_left",  16'(bus.cards_left), 16'd52);

        // LFSR states 5670, AB38, 559C give candidates 1, 9, 13.
        bus.deal = 1'b1;
        @(posedge slow_clock); #1;
        check("deal1_card", 16'(bus.new_card), 16'd1);
        @(posedge slow_clock); #1;
        check("deal2_card", 16'(bus.new_card), 16'd9);
        @(posedge slow_clock); #1;
        check("deal3_card", 16'(bus.new_card), 16'd13);
`ifdef CARD_SHOE_TRACK_EN
        check("deal3_left", 16'(bus.cards_left), 16'd49);
`else
        check("deal3_left", 16'(bus.cards_left), 16'd52);
`endif
        bus.deal = 1'b0;

`ifdef CARD_SHOE_TRACK_EN
        // Whole shoe: every rank exactly four times, then empty.
        do_reset();
        deal_n(52);
        check_hist(4);
        check("empty_valid", 16'(bus.card_valid), 16'd0);
        check("empty_card",  16'(bus.new_card),   16'd0);
        check("empty_left",  16'(bus.cards_left), 16'd0);
        check("empty_low",   16'(bus.shoe_low),   16'd1);
        bus.deal = 1'b1;
        @(posedge slow_clock); #1;
        bus.deal = 1'b0;
        check("empty_deal_valid", 16'(bus.card_valid), 16'd0);
        check("empty_deal_card",  16'(bus.new_card),   16'd0);
        check("empty_deal_left",  16'(bus.cards_left), 16'd0);
        check("empty_shuffle_low", 16'(bus.shoe_low),  16'd1);

        // shoe_low threshold and shuffle refill.
        do_reset();
        deal_n(46);
        check("left46",  16'(bus.cards_left), 16'd6);
        check("low46",   16'(bus.shoe_low),   16'd0);
        deal_n(1);
        check("left47",  16'(bus.cards_left), 16'd5);
        check("low47",   16'(bus.shoe_low),   16'd1);
        check("valid47", 16'(bus.card_valid), 16'd1);
        bus.shuffle = 1'b1;
        @(posedge slow_clock); #1;
        bus.shuffle = 1'b0;
        check("shuf_left",  16'(bus.cards_left), 16'd52);
        check("shuf_low",   16'(bus.shoe_low),   16'd0);
        check("shuf_valid", 16'(bus.card_valid), 16'd0);
        check("shuf_card",  16'(bus.new_card),   16'd0);
        @(posedge slow_clock); #1;
        check("shuf_ready_valid", 16'(bus.card_valid), 16'd1);
        check("shuf_ready_card",  16'(bus.new_card),   cand_of(m_used));

        // Deal and shuffle together: shuffle wins and the full shoe is intact.
        do_reset();
        deal_n(22);
        check("left30", 16'(bus.cards_left), 16'd30);
        bus.deal    = 1'b1;
        bus.shuffle = 1'b1;
        @(posedge slow_clock); #1;
        bus.deal    = 1'b0;
        bus.shuffle = 1'b0;
        check("dealshuf_left",  16'(bus.cards_left), 16'd52);
        check("dealshuf_valid", 16'(bus.card_valid), 16'd0);
        @(posedge slow_clock); #1;
        for (int r = 0; r < 16; r++) hist[r] = 0;
        deal_n(52);
        check_hist(4);
        check("dealshuf_drain_left", 16'(bus.cards_left), 16'd0);
`else
        // Infinite shoe: cards follow the LFSR candidate and nothing depletes.
        do_reset();
        bus.deal = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge slow_clock); #1;
            check("inf_card",  16'(bus.new_card),   cand_of(m_used));
            check("inf_range", 16'(bus.new_card >= 4'd1 && bus.new_card <= 4'd13), 16'd1);
            check("inf_valid", 16'(bus.card_valid), 16'd1);
            check("inf_left",  16'(bus.cards_left), 16'd52);
            check("inf_low",   16'(bus.shoe_low),   16'd0);
        end
        bus.deal    = 1'b0;
        bus.shuffle = 1'b1;
        @(posedge slow_clock); #1;
        bus.shuffle = 1'b0;
        check("inf_shuf_valid", 16'(bus.card_valid), 16'd0);
        check("inf_shuf_card",  16'(bus.new_card),   16'd0);
        @(posedge slow_clock); #1;
        check("inf_ready_valid", 16'(bus.card_valid), 16'd1);
        check("inf_ready_card",  16'(bus.new_card),   cand_of(m_used));
`endif

        // Asynchronous reset between deals takes effect without a clock edge.
        do_reset();
        deal_n(12);
`ifdef CARD_SHOE_TRACK_EN
        check("pre_async_left", 16'(bus.cards_left), 16'd40);
`else
        check("pre_async_left", 16'(bus.cards_left), 16'd52);
`endif
        bus.deal = 1'b1;
        #2;
        resetb = 1'b0;
        #1;
        check("async_card",  16'(bus.new_card),   16'd0);
        check("async_valid", 16'(bus.card_valid), 16'd0);
        check("async_left",  16'(bus.cards_left), 16'd52);
        check("async_low",   16'(bus.shoe_low),   16'd0);
        bus.deal = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock); #1;
        check("post_async_card", 16'(bus.new_card), 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/card_shoe.md
# card_shoe

Card source feeding the baccarat card registers: presents the next card to be dealt, removes it from a finite multi-deck shoe when any load strobe from the game state machine fires, and refills on request. Sits directly upstream of the player/dealer card registers and the hand scorers. Its `new_card` is latched by whichever `load_*card*` strobe is active, and its `deal` input is the OR of all six strobes.

## Interface
Parameters:
- DECKS, 1, number of 52-card decks in the shoe (1..8)
- RESHUFFLE_AT, 6, `shoe_low` asserts when `cards_left` < this value

Ports:
- slow_clock  input  1  game clock; all state changes on its rising edge
- resetb  input  1  reset, asynchronous and active-low
- deal  input  1  consume the presented card this cycle
- shuffle  input  1  refill the shoe to full
- new_card  output  4  presented card: 1=A … 13=K; 0 = no card
- card_valid  output  1  `new_card` is dealable
- cards_left  output  9  cards remaining in the shoe, including the presented card
- shoe_low  output  1  `cards_left` < RESHUFFLE_AT

## Operation
- Per-rank counters `cnt[1..13]`, 6 bits each. Full value is DECKS*4. `cards_left` = sum, range 0..416.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Reset value 16'hACE1. Advances every cycle in every state.
- Candidate rank: c = lfsr[3:0]; if c ≥ 13 then c = c − 13; candidate = c + 1.
- Selection: the first rank r in candidate, candidate+1, … with wrap 13→1 where `cnt[r]` > 0. No such rank means the shoe is empty. Selection uses the current LFSR value, before it advances.
- FSM states:
  - PRIME: entered on reset. Counts full, `new_card`=0, `card_valid`=0. Next cycle → READY, registering `new_card` = selection from the reset counts.
  - READY: `card_valid`=1.
    - `deal`: decrement `cnt[new_card]`, then register a new selection computed from the decremented counts.
    - Without `deal`: `new_card` holds.
    - If the decrement empties the shoe → EMPTY.
  - EMPTY: `new_card`=0, `card_valid`=0. `deal` is ignored.
- `shuffle` in READY or EMPTY: all counts → full, state → PRIME. The shoe returns to READY one cycle later.
- Simultaneous `deal` and `shuffle`: `shuffle` wins; the presented card is not counted.
- `deal` while `card_valid`=0: no effect.
- Counters never underflow. Decrement happens only on a valid deal of a nonzero rank.

## Timing
- Reset values: `new_card`=0, `card_valid`=0, `cards_left`=DECKS*52, `shoe_low`=0 (RESHUFFLE_AT ≤ 52), state PRIME, LFSR 16'hACE1.
- First valid card one edge after reset release: `new_card`=2 (LFSR nibble 1), `card_valid`=1.
- `new_card`, `card_valid` and `cards_left` are registered. After a deal at edge N, the replacement card is stable after edge N.
- Deals on back-to-back cycles are supported. Latency is zero: the card presented during the `deal` cycle is the one latched downstream at that edge.
- `shoe_low` and `cards_left` update on the same edge as the count change.
- Asynchronous reset mid-round: immediate return to reset values. A deal in flight is discarded.

## Configuration
- CARD_SHOE_TRACK_EN defined: finite shoe, behaving as described above.
- Not defined: infinite shoe.
  - Counts are never decremented, so every rank is always available.
  - EMPTY is unreachable; `cards_left` stays at DECKS*52 and `shoe_low` stays 0.
  - The selection equals the candidate rank.
  - `shuffle` still passes through PRIME for one cycle.

## Test plan
- Reset, release, one edge → `card_valid` 0→1, `new_card`=2, `cards_left`=52.
- DECKS=1, `deal` held for 52 cycles → each rank 1..13 observed exactly 4 times. Then `card_valid`=0, `new_card`=0, `cards_left`=0. A further `deal` leaves all outputs unchanged.
- DECKS=1, 47 deals → `cards_left`=5, `shoe_low`=1. Pulse `shuffle` → next edge `cards_left`=52, `shoe_low`=0, `card_valid`=0; following edge `card_valid`=1.
- `deal` and `shuffle` asserted together with `cards_left`=30 → `cards_left`=52; no count is lost from the presented rank.
- Assert `resetb` low between two deals with `cards_left`=40 → outputs return to reset values immediately, without waiting for an edge.
- CARD_SHOE_TRACK_EN undefined, 200 consecutive deals → `card_valid` stays 1, `cards_left` stays 52, every `new_card` is in 1..13.
